// File: rtl/demux1to8_seq.sv
// rtl/demux1to8_seq.sv - serial-to-parallel 1-to-8 demux; each accepted bit fills slot y[sel]
// Optional even-parity trailer bit and PAR state when DEMUX_PARITY_EN is defined.
module demux1to8_seq #(
  parameter int N  = 8,
  parameter int SW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          clr,
  input  logic          din,
  input  logic          din_valid,
  output logic [N-1:0]  y,
  output logic          y_valid,
  output logic          busy,
  output logic [SW-1:0] sel,
  output logic          parity_err
);

  typedef enum logic [1:0] {IDLE, RECV, PAR} state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  shadow_q;
  logic [N-1:0]  y_q;
  logic [SW-1:0] sel_q;
  logic          y_valid_q;
  logic          accept;
  logic          done;
  logic          last_slot;

  assign last_slot = (sel_q == SW'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // accept: a data bit is written to the shadow; done: the word is published on y
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) state_d = RECV;
        end
        RECV: begin
          if (din_valid) begin
            accept = 1'b1;
            if (last_slot) begin
`ifdef DEMUX_PARITY_EN
              state_d = PAR;
`else
              state_d = IDLE;
              done    = 1'b1;
`endif
            end
          end
        end
        PAR: begin
`ifdef DEMUX_PARITY_EN
          if (din_valid) begin
            state_d = IDLE;
            done    = 1'b1;
          end
`else
          state_d = IDLE;
`endif
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      sel_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= done;
      if (clr) begin
        shadow_q <= '0;
        sel_q    <= '0;
      end else begin
        if (state_q == IDLE && start) sel_q <= '0;
        if (accept) begin
          shadow_q[sel_q] <= din;
          sel_q           <= sel_q + SW'(1);
        end
        // clearing the shadow on completion overrides the final slot write above
        if (done) begin
`ifdef DEMUX_PARITY_EN
          y_q <= shadow_q;
`else
          y_q <= {din, shadow_q[N-2:0]};
`endif
          shadow_q <= '0;
        end
      end
    end
  end

`ifdef DEMUX_PARITY_EN
  logic parity_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (done) begin
      parity_err_q <= (^shadow_q) ^ din;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign y       = y_q;
  assign y_valid = y_valid_q;
  assign busy    = (state_q != IDLE);
  assign sel     = sel_q;

endmodule

// File: tb/tb_demux1to8_seq.sv
// tb/tb_demux1to8_seq.sv - directed self-checking bench for demux1to8_seq
module tb_demux1to8_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clr;
  logic       din;
  logic       din_valid;
  logic [7:0] y;
  logic       y_valid;
  logic       busy;
  logic [2:0] sel;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  demux1to8_seq #(.N(8), .SW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .clr        (clr),
    .din        (din),
    .din_valid  (din_valid),
    .y          (y),
    .y_valid    (y_valid),
    .busy       (busy),
    .sel        (sel),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic send_bit(input logic b);
    din       = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Receives one word; returns in the y_valid cycle.
  task automatic recv_word(input logic [7:0] w, input logic par_bit, input logic exp_perr,
                           input bit stall);
    logic [7:0] wv;
    wv    = w;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_sel", sel, 0);
    for (int i = 0; i < 8; i++) begin
      send_bit(wv[i]);
      if (i < 7) begin
        check("recv_sel", sel, i + 1);
        check("recv_valid", y_valid, 0);
        if (stall && (i == 1 || i == 4)) begin
          for (int s = 0; s < 2; s++) begin
            tick();
            check("stall_sel", sel, i + 1);
            check("stall_busy", busy, 1);
          end
        end
      end
    end
`ifdef DEMUX_PARITY_EN
    check("par_busy", busy, 1);
    check("par_valid", y_valid, 0);
    send_bit(par_bit);
    check("parity_err", parity_err, exp_perr);
`else
    check("parity_tied", parity_err, 0);
    if (par_bit !== exp_perr) check("par_args", 1, 0);
`endif
    check("word_valid", y_valid, 1);
    check("word_y", y, w);
    check("word_busy", busy, 0);
    check("word_sel", sel, 0);
  endtask

  int t1, t2, t0;

  initial begin
    rst_n = 1'b0; start = 1'b0; clr = 1'b0; din = 1'b0; din_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_y", y, 8'h00);
      check("rst_busy", busy, 0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_y", y, 8'h00);
      check("idle_valid", y_valid, 0);
      check("idle_busy", busy, 0);
      check("idle_sel", sel, 0);
      check("idle_perr", parity_err, 0);
    end

    // Data bits present during the start cycle must be ignored.
    din = 1'b1; din_valid = 1'b1;
    recv_word(8'h4D, 1'b0, 1'b0, 1'b0);
    tick();
    check("pulse_len", y_valid, 0);
    check("hold_y", y, 8'h4D);

    tick();
    recv_word(8'h4D, 1'b0, 1'b0, 1'b1);
    t1 = cyc;
    recv_word(8'hA5, 1'b0, 1'b0, 1'b0);
    t2 = cyc;
`ifdef DEMUX_PARITY_EN
    check("b2b_period", t2 - t1, 10);
`else
    check("b2b_period", t2 - t1, 9);
`endif
    tick();
    check("b2b_pulse_len", y_valid, 0);

    // Abort after 5 bits.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("pre_clr_sel", sel, 5);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_sel", sel, 0);
    check("clr_busy", busy, 0);
    check("clr_valid", y_valid, 0);
    check("clr_y", y, 8'hA5);
    tick();
    check("clr_valid2", y_valid, 0);

    // clr beats start in the same cycle.
    clr = 1'b1; start = 1'b1;
    tick();
    clr = 1'b0; start = 1'b0;
    check("clr_prio_busy", busy, 0);

    // Asynchronous reset between edges mid-word.
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    check("pre_rst_sel", sel, 3);
    #2 rst_n = 1'b0;
    #1;
    check("async_y", y, 8'h00);
    check("async_sel", sel, 0);
    check("async_busy", busy, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_valid", y_valid, 0);
    check("post_rst_y", y, 8'h00);

`ifdef DEMUX_PARITY_EN
    t0 = cyc;
    recv_word(8'h4D, 1'b0, 1'b0, 1'b0);
    check("par_latency", cyc - t0, 10);
    tick();
    check("perr_hold", parity_err, 0);
    recv_word(8'h4D, 1'b1, 1'b1, 1'b0);
    tick();
    check("perr_hold1", parity_err, 1);
`else
    t0 = cyc;
    recv_word(8'h96, 1'b0, 1'b0, 1'b0);
    check("latency", cyc - t0, 9);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
